// File: rtl/rr_request_arbiter.sv
// Grants one of N requesters at a time and holds the grant until release, request drop or
// hold-budget expiry. Winner is round-robin after the last owner, or highest index in fixed mode.
module rr_request_arbiter #(
    parameter int unsigned N          = 16,
    parameter int unsigned IDW        = 4,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_HOLD   = 255,
    parameter int unsigned HOLD_W     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           release_i,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout_o
);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [IDW-1:0]      gnt_id_q, gnt_id_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDW-1:0]      last_q, last_d;
    logic                timeout_q, timeout_d;

    logic [IDW-1:0]      win_id;
    logic                win_found;
    logic                budget_hit;
    int unsigned         idx;

    // Winner selection; the round-robin scan visits last_q+1 .. last_q (inclusive) modulo N.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        idx       = 0;
        if (FIXED_PRIO != 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (req[i[IDW-1:0]]) begin
                    win_id    = i[IDW-1:0];
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = (32'(last_q) + k) % N;
                if (!win_found && req[idx[IDW-1:0]]) begin
                    win_id    = idx[IDW-1:0];
                    win_found = 1'b1;
                end
            end
        end
    end

    assign budget_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        timeout_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d        = StOwned;
                    gnt_d          = '0;
                    gnt_d[win_id]  = 1'b1;
                    gnt_id_d       = win_id;
                    hold_cnt_d     = HOLD_W'(1);
                    last_d         = win_id;
                end
            end
            StOwned: begin
                if (release_i || !req[gnt_id_q] || budget_hit) begin
                    state_d    = StIdle;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                    // Release and request drop take precedence over the budget.
                    timeout_d  = !release_i && req[gnt_id_q];
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            hold_cnt_q <= '0;
            last_q     <= IDW'(N - 1);
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == StOwned);
    assign gnt_id    = gnt_id_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Scoreboard bench: two arbiter instances (round-robin with budget 4, fixed priority without
// budget); expected grants are queued by the stimulus and checked by an independent monitor.
module tb_rr_request_arbiter;

    typedef struct {
        int dut;
        int id;
        int len;
        bit tmo;
    } exp_t;

    logic        clk;
    logic        rst_a  [2];
    logic [15:0] req_a  [2];
    logic        rel_a  [2];
    logic [15:0] gnt_a  [2];
    logic        gv_a   [2];
    logic [3:0]  id_a   [2];
    logic        tmo_a  [2];

    exp_t exp_q[$];
    exp_t cur[2];
    int   run_len[2];
    bit   prev_v[2];
    bit   active[2];
    bit   mon_en;
    int   tests;
    int   fails;

    rr_request_arbiter #(
        .N(16), .IDW(4), .FIXED_PRIO(0), .MAX_HOLD(4), .HOLD_W(3)
    ) u_rr (
        .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .release_i(rel_a[0]),
        .gnt(gnt_a[0]), .gnt_valid(gv_a[0]), .gnt_id(id_a[0]), .timeout_o(tmo_a[0])
    );

    rr_request_arbiter #(
        .N(16), .IDW(4), .FIXED_PRIO(1), .MAX_HOLD(0), .HOLD_W(8)
    ) u_fp (
        .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .release_i(rel_a[1]),
        .gnt(gnt_a[1]), .gnt_valid(gv_a[1]), .gnt_id(id_a[1]), .timeout_o(tmo_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, d, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int id, input int len, input bit tmo);
        exp_t e;
        e.dut = d;
        e.id  = id;
        e.len = len;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic idle_chk(input int d);
        @(negedge clk);
        chk("idle_gnt", d, 32'(gnt_a[d]), 32'h0);
        chk("idle_valid", d, 32'(gv_a[d]), 32'h0);
        chk("idle_id", d, 32'(id_a[d]), 32'h0);
        chk("idle_timeout", d, 32'(tmo_a[d]), 32'h0);
    endtask

    // Called in grant cycle 1; pulses release in grant cycle len, returns in the bubble.
    task automatic run_release(input int d, input int len);
        repeat (len - 1) step();
        rel_a[d] = 1'b1;
        step();
        rel_a[d] = 1'b0;
    endtask

    // Monitor: per-cycle invariants plus grant id / length / timeout against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk("gnt_vs_id", d, 32'(gnt_a[d]), gv_a[d] ? (32'(1) << id_a[d]) : 32'(0));
                    chk("gnt_valid", d, 32'(gv_a[d]), 32'(|gnt_a[d]));
                    if (!gv_a[d]) chk("gnt_id_idle", d, 32'(id_a[d]), 32'h0);
                    chk("timeout_o", d, 32'(tmo_a[d]),
                        32'(!gv_a[d] && prev_v[d] && active[d] && cur[d].tmo));
                    if (gv_a[d] && !prev_v[d]) begin
                        if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                            tests++;
                            fails++;
                            active[d] = 1'b0;
                            $display("FAIL unexpected_grant (dut%0d): got id %0d, expected none",
                                     d, id_a[d]);
                        end else begin
                            cur[d]    = exp_q.pop_front();
                            active[d] = 1'b1;
                            run_len[d] = 1;
                            chk("grant_id", d, 32'(id_a[d]), 32'(cur[d].id));
                        end
                    end else if (gv_a[d]) begin
                        run_len[d]++;
                    end else if (prev_v[d] && active[d]) begin
                        chk("grant_len", d, 32'(run_len[d]), 32'(cur[d].len));
                        active[d] = 1'b0;
                    end
                    prev_v[d] = gv_a[d];
                end
            end
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst_a[d]   = 1'b1;
            rel_a[d]   = 1'b0;
            prev_v[d]  = 1'b0;
            active[d]  = 1'b0;
            run_len[d] = 0;
        end
        req_a[0] = 16'hFFFF;
        req_a[1] = 16'h0000;

        // Reset with all requests asserted, then first RR grant goes to index 0.
        step();
        mon_en = 1'b1;
        step();
        idle_chk(0);
        idle_chk(1);
        rst_a[1] = 1'b0;
        push(0, 0, 3, 1'b0);
        rst_a[0] = 1'b0;
        step();
        run_release(0, 3);
        req_a[0] = 16'h0000;
        step();

        // Round-robin fairness between indices 0 and 15.
        rst_a[0] = 1'b1;
        step();
        rst_a[0] = 1'b0;
        req_a[0] = 16'h8001;
        push(0, 0, 3, 1'b0);
        push(0, 15, 3, 1'b0);
        push(0, 0, 3, 1'b0);
        push(0, 15, 3, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            run_release(0, 3);
            if (i < 3) step();
        end
        req_a[0] = 16'h0000;
        step();

        // Hold budget of 4: two consecutive timeouts on requester 3.
        push(0, 3, 4, 1'b1);
        push(0, 3, 4, 1'b1);
        req_a[0] = 16'h0008;
        step();
        repeat (4) step();
        step();
        repeat (4) step();
        req_a[0] = 16'h0000;
        step();

        // Release on the budget edge wins over timeout.
        push(0, 3, 4, 1'b0);
        req_a[0] = 16'h0008;
        step();
        run_release(0, 4);
        req_a[0] = 16'h0000;
        step();

        // Reset mid-grant with release asserted, then RR restarts from 0.
        push(0, 4, 2, 1'b0);
        req_a[0] = 16'h0030;
        step();
        step();
        rst_a[0] = 1'b1;
        rel_a[0] = 1'b1;
        req_a[0] = 16'hFFFF;
        step();
        idle_chk(0);
        rst_a[0] = 1'b0;
        rel_a[0] = 1'b0;
        push(0, 0, 3, 1'b0);
        step();
        run_release(0, 3);
        req_a[0] = 16'h0000;
        step();

        // Fixed priority: 7 beats 4, no budget so a long hold survives, 4 may be re-granted.
        push(1, 7, 300, 1'b0);
        push(1, 4, 2, 1'b0);
        push(1, 4, 2, 1'b0);
        req_a[1] = 16'h0090;
        step();
        repeat (299) step();
        req_a[1] = 16'h0010;
        step();
        step();
        run_release(1, 2);
        step();
        run_release(1, 2);
        req_a[1] = 16'h0000;
        repeat (3) step();

        @(negedge clk);
        chk("queue_empty", 0, 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
